// File: rtl/psum_deskew_collector.sv
// Deskews bottom-row partial sums of a systolic array into aligned vectors
// and buffers them in a small output-registered FIFO. Column c of a vector
// that entered row 0 at cycle t is captured at t+PIPE_LAT+c and delayed by
// NUM_COLS-1-c cycles, so every column lines up at t+PIPE_LAT+NUM_COLS-1.
// PIPE_LAT must be at least 1.
module psum_deskew_collector #(
  parameter int NUM_COLS   = 16,
  parameter int PIPE_LAT   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic signed [NUM_COLS*32-1:0] in_sum,
  output logic [NUM_COLS*32-1:0]     out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       ovf_err,
  output logic                       busy
);

  localparam int L  = PIPE_LAT + NUM_COLS - 1;  // age at completion
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = NUM_COLS * 32;

  // vld_q[a]/lst_q[a]: a vector of age a (entered a cycles ago) is in flight
  logic [L:1] vld_q, lst_q;
  logic [NUM_COLS-1:0][31:0] col_aligned;

  // In-flight tracking shift register; FLUSH also swallows a same-cycle in_valid
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[1] <= in_valid;
      lst_q[1] <= in_valid & in_last;
      for (int a = 2; a <= L; a++) begin
        vld_q[a] <= vld_q[a-1];
        lst_q[a] <= lst_q[a-1];
      end
    end
  end

  // Per-column skew delay; the last column arrives exactly at completion
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    if (c == NUM_COLS - 1) begin : g_live
      assign col_aligned[c] = in_sum[c*32 +: 32];
    end else begin : g_dly
      localparam int DL = NUM_COLS - 1 - c;
      logic [31:0] dl_q [DL];
      // Stage j only moves when the vector it belongs to is tracked
      always_ff @(posedge CLK) begin
        if (vld_q[PIPE_LAT+c]) dl_q[0] <= in_sum[c*32 +: 32];
        for (int j = 1; j < DL; j++)
          if (vld_q[PIPE_LAT+c+j]) dl_q[j] <= dl_q[j-1];
      end
      assign col_aligned[c] = dl_q[DL-1];
    end
  end

  logic                          cmpl, full, pop, push, drop;
  logic [FIFO_DEPTH-1:0][DW-1:0] mem_q;
  logic [FIFO_DEPTH-1:0]         mlast_q;
  logic [AW-1:0]                 wp_q, rp_q;
  logic [AW:0]                   cnt_q, cnt_d;
  logic                          ovf_q;

  assign cmpl = vld_q[L];
  assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts when a pop frees a slot in the same cycle
  assign push = cmpl & (~full | pop);
  assign drop = cmpl & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  // FIFO storage, pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_q   <= '0;
      mlast_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (FLUSH) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wp_q]   <= col_aligned;
        mlast_q[wp_q] <= lst_q[L];
        wp_q          <= wp_q + AW'(1);
      end
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Head entry is read straight from storage: no path from write to read
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rp_q];
  assign out_last  = mlast_q[rp_q];
  assign ovf_err   = ovf_q;
  assign busy      = (|vld_q) | out_valid;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Directed bench for psum_deskew_collector with NUM_COLS=4, PIPE_LAT=3,
// FIFO_DEPTH=2. Each scenario fills a per-cycle stimulus schedule, runs it,
// logs outputs per cycle, then compares the log against hand-derived values.
module tb_psum_deskew_collector;
  localparam int NC = 4, PL = 3, FD = 2, W = NC*32, MAXC = 64;

  logic CLK = 1'b0;
  logic RESET, FLUSH, in_valid, in_last, out_valid, out_last, out_ready, ovf_err, busy;
  logic [W-1:0] in_sum, out_data;

  always #5 CLK = ~CLK;

  psum_deskew_collector #(.NUM_COLS(NC), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .in_valid(in_valid), .in_last(in_last),
    .in_sum(in_sum), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .ovf_err(ovf_err), .busy(busy));

  int total = 0, bad = 0, cyc = 0;

  logic         sv_valid[MAXC], sv_last[MAXC], sv_flush[MAXC], sv_rst[MAXC], sv_rdy[MAXC];
  logic [W-1:0] sv_sum[MAXC];
  logic         lg_ov[MAXC], lg_busy[MAXC], lg_ovf[MAXC], lg_last[MAXC];
  logic [W-1:0] lg_data[MAXC];

  typedef struct { int cyc; logic [W-1:0] d; logic l; } xfer_t;
  xfer_t xq[$];

  typedef struct { int t; logic last; logic [W-1:0] d; int oc; } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int base);
    logic [W-1:0] r;
    for (int c = 0; c < NC; c++) r[c*32 +: 32] = 32'(base + c);
    return r;
  endfunction

  task automatic clear(input bit junk, input bit rdy);
    for (int i = 0; i < MAXC; i++) begin
      sv_valid[i] = 0; sv_last[i] = 0; sv_flush[i] = 0; sv_rst[i] = 0; sv_rdy[i] = rdy;
      sv_sum[i]   = junk ? {NC{32'hBAD00000 | 32'(i)}} : '0;
      lg_ov[i] = 0; lg_busy[i] = 0; lg_ovf[i] = 0; lg_last[i] = 0; lg_data[i] = '0;
    end
    xq.delete();
  endtask

  // Vector issued at cycle t: column c presented on in_sum at t+PL+c
  task automatic sched(input int t, input logic last, input logic [W-1:0] d);
    sv_valid[t] = 1'b1;
    sv_last[t]  = last;
    for (int c = 0; c < NC; c++) sv_sum[t+PL+c][c*32 +: 32] = d[c*32 +: 32];
  endtask

  task automatic do_reset();
    RESET = 1; FLUSH = 0; in_valid = 0; in_last = 0; in_sum = '0; out_ready = 0;
    @(posedge CLK); #1;
    RESET = 0;
    cyc = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      cyc++;
      in_valid  = sv_valid[cyc]; in_last = sv_last[cyc]; in_sum = sv_sum[cyc];
      FLUSH     = sv_flush[cyc]; RESET   = sv_rst[cyc];  out_ready = sv_rdy[cyc];
      lg_ov[cyc] = out_valid; lg_busy[cyc] = busy; lg_ovf[cyc] = ovf_err;
      lg_data[cyc] = out_data; lg_last[cyc] = out_last;
      if (out_valid && out_ready) xq.push_back('{cyc, out_data, out_last});
    end
  endtask

  initial begin
    int n;

    // ---- S1: reset state, then single vector latency and data
    clear(0, 1);
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_ovf_err",   ovf_err, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_out_data",  out_data, '0);
    sched(10, 0, mk(100));
    run(25);
    chk("s1_no_early_valid", lg_ov[16], 0);
    chk("s1_busy_in_flight", lg_busy[11], 1);
    chk("s1_xfer_count", xq.size(), 1);
    if (xq.size() >= 1) begin
      chk("s1_out_cycle", xq[0].cyc, 17);
      chk("s1_out_data",  xq[0].d, {32'd103, 32'd102, 32'd101, 32'd100});
      chk("s1_out_last",  xq[0].l, 0);
    end
    chk("s1_idle_busy", lg_busy[24], 0);

    // ---- S2: streaming back-to-back with junk on unsampled slots
    tbl[0] = '{10, 1'b0, mk(200), 17};
    tbl[1] = '{11, 1'b0, mk(300), 18};
    tbl[2] = '{12, 1'b0, mk(400), 19};
    tbl[3] = '{13, 1'b1, mk(500), 20};
    clear(1, 1);
    do_reset();
    for (int i = 0; i < 4; i++) sched(tbl[i].t, tbl[i].last, tbl[i].d);
    run(30);
    chk("s2_xfer_count", xq.size(), 4);
    for (int i = 0; i < 4 && i < xq.size(); i++) begin
      chk($sformatf("s2_cycle[%0d]", i), xq[i].cyc, tbl[i].oc);
      chk($sformatf("s2_data[%0d]", i),  xq[i].d,   tbl[i].d);
      chk($sformatf("s2_last[%0d]", i),  xq[i].l,   tbl[i].last);
    end

    // ---- S3: backpressure overflow, drain, then flush clears ovf_err
    clear(0, 0);
    for (int t = 11; t <= 13; t++) sched(t, 0, mk(t*10));
    for (int i = 25; i < MAXC; i++) sv_rdy[i] = 1;
    sv_flush[40] = 1;
    do_reset();
    run(45);
    chk("s3_valid_blocked", lg_ov[19], 1);
    chk("s3_ovf_before",    lg_ovf[19], 0);
    chk("s3_ovf_set",       lg_ovf[20], 1);
    chk("s3_ovf_sticky",    lg_ovf[39], 1);
    chk("s3_ovf_flushed",   lg_ovf[41], 0);
    chk("s3_xfer_count",    xq.size(), 2);
    if (xq.size() >= 2) begin
      chk("s3_x0_data",  xq[0].d, mk(110));
      chk("s3_x0_cycle", xq[0].cyc, 25);
      chk("s3_x1_data",  xq[1].d, mk(120));
      chk("s3_x1_cycle", xq[1].cyc, 26);
    end

    // ---- S4: full FIFO with a pop in the completion cycle
    clear(0, 0);
    sched(10, 0, mk(1000));
    sched(11, 0, mk(2000));
    sched(12, 1, mk(3000));
    sv_rdy[18] = 1;
    for (int i = 25; i < MAXC; i++) sv_rdy[i] = 1;
    do_reset();
    run(35);
    chk("s4_ovf", lg_ovf[30], 0);
    chk("s4_xfer_count", xq.size(), 3);
    if (xq.size() >= 3) begin
      chk("s4_x0", {xq[0].d, 32'(xq[0].cyc)}, {mk(1000), 32'd18});
      chk("s4_x1", {xq[1].d, 32'(xq[1].cyc)}, {mk(2000), 32'd25});
      chk("s4_x2", {xq[2].d, 32'(xq[2].cyc)}, {mk(3000), 32'd26});
      chk("s4_x2_last", xq[2].l, 1);
    end

    // ---- S5: flush mid-flight, in_valid alongside FLUSH dropped
    clear(0, 1);
    sched(10, 0, mk(7));
    sched(14, 0, mk(8));
    sv_flush[14] = 1;
    do_reset();
    run(30);
    chk("s5_busy_before", lg_busy[14], 1);
    chk("s5_busy_after",  lg_busy[15], 0);
    n = 0;
    for (int i = 0; i < MAXC; i++) n += int'(lg_ov[i]);
    chk("s5_valid_cycles", n, 0);
    chk("s5_xfer_count", xq.size(), 0);

    // ---- S6: reset (with flush) while 2 buffered + 1 in flight
    clear(0, 0);
    sched(10, 0, mk(40));
    sched(11, 0, mk(50));
    sched(14, 0, mk(60));
    sched(18, 0, mk(70));
    sv_rst[18] = 1;
    sv_flush[18] = 1;
    for (int i = 20; i < MAXC; i++) sv_rdy[i] = 1;
    do_reset();
    run(35);
    chk("s6_pre_valid", lg_ov[18], 1);
    chk("s6_pre_busy",  lg_busy[18], 1);
    chk("s6_rst_valid", lg_ov[19], 0);
    chk("s6_rst_busy",  lg_busy[19], 0);
    chk("s6_rst_ovf",   lg_ovf[19], 0);
    chk("s6_rst_data",  lg_data[19], '0);
    chk("s6_rst_last",  lg_last[19], 0);
    n = 0;
    for (int i = 19; i < MAXC; i++) n += int'(lg_ov[i]);
    chk("s6_stale_valid", n, 0);
    chk("s6_xfer_count", xq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_deskew_collector.md
PSUM_DESKEW_COLLECTOR -- requirements
Module: psum_deskew_collector

Interface
REQ-001 The block SHALL have parameter NUM_COLS, default 16: number of array columns.
REQ-002 The block SHALL have parameter PIPE_LAT, default 32: cycles from a vector entering array row 0 to its column-0 sum appearing on in_sum.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8: number of buffered output vectors, power of two, at least 2.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic rising-edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port FLUSH, input, 1 bit: synchronous clear of in-flight tracking and FIFO.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an activation vector enters array row 0 this cycle.
REQ-008 The block SHALL have port in_last, input, 1 bit: qualifies in_valid; marks the last vector of a tile.
REQ-009 The block SHALL have port in_sum, input signed, NUM_COLS*32 bits: bottom-row psums from the array; column c is bits [c*32+31:c*32].
REQ-010 The block SHALL have port out_data, output, NUM_COLS*32 bits: deskewed result vector, same column packing as in_sum.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data/out_last hold a valid vector.
REQ-012 The block SHALL have port out_last, output, 1 bit: the in_last tag of the vector on out_data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts a vector.
REQ-014 The block SHALL have port ovf_err, output, 1 bit: sticky flag; a completed vector was dropped.
REQ-015 The block SHALL have port busy, output, 1 bit: at least one vector is in flight or buffered.

Function
REQ-016 For in_valid at cycle t, the block SHALL sample column c of in_sum at cycle t+PIPE_LAT+c.
REQ-017 The vector SHALL complete at cycle t+PIPE_LAT+NUM_COLS-1 with all columns aligned, bit-exact, and no arithmetic applied.
REQ-018 A completed vector SHALL be written to the FIFO at the end of its completion cycle, together with its in_last tag.
REQ-019 The earliest out_valid for a vector SHALL be cycle t+PIPE_LAT+NUM_COLS.
REQ-020 in_valid SHALL be accepted every cycle, with no backpressure toward the array.
REQ-021 Back-to-back vectors SHALL be tracked independently.
REQ-022 in_sum SHALL be ignored in cycles where no tracked vector samples it.
REQ-023 Output handshake: a transfer SHALL occur when out_valid and out_ready are both 1.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-025 The FIFO SHALL be first-in first-out and output-registered.
REQ-026 out_valid SHALL be 1 whenever the FIFO is non-empty.
REQ-027 On a write to a full FIFO with a pop in the same cycle, the write SHALL be accepted and occupancy SHALL be unchanged.
REQ-028 On a write to a full FIFO with no pop, the vector SHALL be dropped, FIFO contents SHALL be unchanged, and ovf_err SHALL be set.
REQ-029 On a simultaneous write and pop on an empty FIFO, there SHALL be no bypass; out_valid rises the next cycle.
REQ-030 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 ovf_err SHALL clear only on RESET or FLUSH.
REQ-032 busy SHALL be 1 when any delay-tracking stage is valid or the FIFO is non-empty.
REQ-033 FLUSH=1 SHALL discard all in-flight vectors and empty the FIFO, so that out_valid=0, busy=0 and ovf_err=0 on the next cycle.
REQ-034 in_valid asserted in the same cycle as FLUSH SHALL be discarded.
REQ-035 If RESET and FLUSH are both asserted, RESET SHALL dominate, with identical result.

Reset
REQ-036 At the first edge with RESET=1, out_valid, out_last, ovf_err and busy SHALL be 0, out_data SHALL be all zero, FIFO pointers SHALL be 0, and all tracking stages SHALL be invalid.
REQ-037 RESET asserted mid-operation SHALL abort all in-flight and buffered vectors, and none SHALL be emitted afterwards.
REQ-038 in_valid during RESET SHALL be ignored.

Verification (NUM_COLS=4, PIPE_LAT=3, FIFO_DEPTH=2)
REQ-039 Single vector: in_valid at cycle 10, with in_sum column c = 100+c at cycle 13+c and other columns 0 -> out_valid at cycle 17 with out_data columns {100,101,102,103} and out_last=0.
REQ-040 Streaming: in_valid on cycles 10..13 with distinct per-vector values and out_ready=1 -> four vectors out on cycles 17..20 in order, last one tagged out_last=1 when in_last was set on cycle 13.
REQ-041 Backpressure/overflow: 3 vectors with out_ready=0 -> first two buffered, third dropped, ovf_err=1 from cycle 20; releasing out_ready then emits exactly 2 vectors, and ovf_err stays 1.
REQ-042 Full with simultaneous pop: FIFO full, out_ready=1 in a vector's completion cycle -> no drop, ovf_err=0, and output order is preserved.
REQ-043 Flush mid-flight: in_valid at cycle 10, FLUSH at cycle 14 -> no out_valid ever; busy=0 at cycle 15.
REQ-044 Reset mid-operation: FIFO holding 2 vectors plus 1 in flight, RESET for 1 cycle -> all outputs 0 next cycle, and no stale vector appears afterwards.
